// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline MEM stage with handshaked data-memory access, alignment
//            checking, bus-timeout abort and MEM/WB output registers.
// Revision : 1.0  initial release
// ============================================================================
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        wwreg,
    output logic        wm2reg,
    output logic [31:0] wmo,
    output logic [31:0] walu,
    output logic [4:0]  wrn,
    output logic        align_err,
    output logic        bus_err
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] c_CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;

    logic        w_memop;
    logic        w_misaligned;
    logic        w_last;

    assign w_memop      = mm2reg | mwmem;
    assign w_misaligned = w_memop & (malu[1:0] != 2'b00);
    assign w_last       = (r_cnt == c_CNT_LAST);

    // Address/data come straight from the frozen EX/MEM register; only the
    // request strobe is owned by this stage.
    assign dmem_req   = (r_state == S_WAIT);
    assign dmem_we    = mwmem;
    assign dmem_addr  = malu;
    assign dmem_wdata = mb;

    always_comb begin
        mem_stall = 1'b0;
        case (r_state)
            S_IDLE:  mem_stall = w_memop & ~w_misaligned;
            S_WAIT:  mem_stall = ~dmem_ack & ~w_last;
            default: mem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            wwreg     <= 1'b0;
            wm2reg    <= 1'b0;
            wmo       <= 32'd0;
            walu      <= 32'd0;
            wrn       <= 5'd0;
            align_err <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            // Default: bubble into MEM/WB
            wwreg     <= 1'b0;
            wm2reg    <= 1'b0;
            wmo       <= 32'd0;
            walu      <= 32'd0;
            wrn       <= 5'd0;
            align_err <= 1'b0;
            bus_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_misaligned) begin
                        walu      <= malu;
                        wrn       <= mrn;
                        align_err <= 1'b1;
                    end else if (w_memop) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 8'd0;
                    end else begin
                        wwreg  <= mwreg;
                        wm2reg <= mm2reg;
                        walu   <= malu;
                        wrn    <= mrn;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        wwreg   <= mwreg;
                        wm2reg  <= mm2reg;
                        wmo     <= mm2reg ? dmem_rdata : 32'd0;
                        walu    <= malu;
                        wrn     <= mrn;
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        walu    <= malu;
                        wrn     <= mrn;
                        bus_err <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
